spi_rx_deserializer: RTL and testbench

//  Receive-side counterpart of the SPI-lite shift-out path: samples serial data (sdi) on

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_bit_counter.sv | 32 +++
 rtl/spi_rx_deserializer.sv | 111 +++++++++++
 tb/tb_spi_rx_deserializer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI-lite definitions: default word width, receiver state encoding and
// bit-order constants used by both the RX deserializer and the TX shifter.
package spi_pkg;

    localparam int SPI_DATAWIDTH = 8;

    localparam logic SPI_LSB_FIRST = 1'b1;
    localparam logic SPI_MSB_FIRST = 1'b0;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_e;

endpackage

// File: rtl/spi_bit_counter.sv
// Modulo-DATAWIDTH bit counter shared by the SPI RX and TX paths.
// Clear has priority over increment; last_o flags the final bit position.
module spi_bit_counter
    import spi_pkg::*;
#(
    parameter int DATAWIDTH = SPI_DATAWIDTH,
    parameter int CNT_W     = $clog2(DATAWIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATAWIDTH - 1);

    // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (clr) begin
            cnt_o <= '0;
        end else if (inc) begin
            cnt_o <= (cnt_o == CNT_LAST) ? '0 : cnt_o + 1'b1;
        end
    end

    assign last_o = (cnt_o == CNT_LAST);

endmodule

// File: rtl/spi_rx_deserializer.sv
// SPI-lite receive path: assembles sdi samples into DATAWIDTH-bit words and hands
// them to the APB side through a valid/ready holding register with sticky overrun.
module spi_rx_deserializer
    import spi_pkg::*;
#(
    parameter int DATAWIDTH = SPI_DATAWIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 sdi,
    input  logic                 sample_en,
    input  logic                 frame_i,
    input  logic                 sh_rl,
    output logic [DATAWIDTH-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 busy_o,
    output logic                 overrun_o,
    input  logic                 clr_ovr_i
);

    localparam int CNT_W = $clog2(DATAWIDTH);

    rx_state_e            state;
    logic                 frame_q;
    logic                 lsb_first;
    logic [DATAWIDTH-1:0] shift_reg;
    logic [DATAWIDTH-1:0] next_word;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 cnt_last;
    logic                 frame_rise;
    logic                 shift_en;
    logic                 word_done;
    logic                 abort;

    assign frame_rise = frame_i && !frame_q;
    assign shift_en   = (state == RX_SHIFT) && frame_i && sample_en;
    assign word_done  = shift_en && cnt_last;
    assign abort      = (state == RX_SHIFT) && !frame_i;

    // NOTE: always_comb assigns a default first so no path can leave next_word unassigned (no latch).
    always_comb begin
        next_word = {shift_reg[DATAWIDTH-2:0], sdi};
        if (lsb_first == SPI_LSB_FIRST) begin
            next_word = {sdi, shift_reg[DATAWIDTH-1:1]};
        end
    end

    spi_bit_counter #(
        .DATAWIDTH (DATAWIDTH),
        .CNT_W     (CNT_W)
    ) u_bit_counter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .inc    (shift_en),
        .clr    (abort),
        .cnt_o  (bit_cnt),
        .last_o (cnt_last)
    );

    // Decoded straight from counter flops, so sdi has no path to busy_o.
    assign busy_o = |bit_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= RX_IDLE;
            // Reset to 1 so a frame_i already high at reset release is not taken as a new frame.
            frame_q   <= 1'b1;
            lsb_first <= SPI_MSB_FIRST;
            shift_reg <= '0;
            data_o    <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            frame_q <= frame_i;

            case (state)
                RX_IDLE: begin
                    if (frame_rise) begin
                        state     <= RX_SHIFT;
                        lsb_first <= sh_rl;
                    end
                end
                RX_SHIFT: begin
                    if (!frame_i) begin
                        state     <= RX_IDLE;
                        shift_reg <= '0;
                    end else if (sample_en) begin
                        shift_reg <= next_word;
                    end
                end
                default: state <= RX_IDLE;
            endcase

            if (word_done && (!valid_o || ready_i)) begin
                data_o  <= next_word;
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end

            // A drop in the same cycle as a clear keeps the flag set.
            if (word_done && valid_o && !ready_i) begin
                overrun_o <= 1'b1;
            end else if (clr_ovr_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_rx_deserializer.sv
// Directed self-checking bench for spi_rx_deserializer (DATAWIDTH = 8).
module tb_spi_rx_deserializer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       sdi;
    logic       sample_en;
    logic       frame_i;
    logic       sh_rl;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       busy_o;
    logic       overrun_o;
    logic       clr_ovr_i;

    int tests_run    = 0;
    int tests_failed = 0;

    spi_rx_deserializer #(.DATAWIDTH(8)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .sdi       (sdi),
        .sample_en (sample_en),
        .frame_i   (frame_i),
        .sh_rl     (sh_rl),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .busy_o    (busy_o),
        .overrun_o (overrun_o),
        .clr_ovr_i (clr_ovr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Strobes bit positions [from, to) of w; position 0 is the first bit on the wire.
    task automatic send_bits(input logic [7:0] w, input int from, input int to, input bit lsb);
        for (int i = from; i < to; i++) begin
            sdi       = lsb ? w[i] : w[7-i];
            sample_en = 1'b1;
            tick();
            sample_en = 1'b0;
        end
    endtask

    task automatic start_frame(input bit lsb);
        sh_rl   = lsb;
        frame_i = 1'b1;
        tick();
    endtask

    task automatic end_frame();
        frame_i = 1'b0;
        tick();
    endtask

    task automatic drain();
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; sdi = 1'b0; sample_en = 1'b0; frame_i = 1'b0;
        sh_rl = 1'b0; ready_i = 1'b0; clr_ovr_i = 1'b0;
        tick(); tick();
        rst_i = 1'b0;
        tick();
        check_byte("reset data_o", data_o, 8'h00);
        check_bit("reset valid_o", valid_o, 1'b0);
        check_bit("reset busy_o", busy_o, 1'b0);
        check_bit("reset overrun_o", overrun_o, 1'b0);
    endtask

    task automatic test_msb_first();
        // Strobe in the same cycle frame_i rises must be ignored.
        sh_rl = 1'b0; frame_i = 1'b1; sdi = 1'b1; sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        check_bit("msb strobe on rise ignored busy", busy_o, 1'b0);
        send_bits(8'hA5, 0, 7, 1'b0);
        check_bit("msb 7 bits busy", busy_o, 1'b1);
        check_bit("msb 7 bits no valid", valid_o, 1'b0);
        send_bits(8'hA5, 7, 8, 1'b0);
        check_byte("msb data", data_o, 8'hA5);
        check_bit("msb valid at 8th edge", valid_o, 1'b1);
        check_bit("msb busy cleared", busy_o, 1'b0);
        end_frame();
        drain();
        check_bit("msb valid cleared by accept", valid_o, 1'b0);
    endtask

    task automatic test_lsb_first();
        start_frame(1'b1);
        sh_rl = 1'b0;  // mid-frame change must not affect order
        // Wire stream 1,1,0,0,0,0,0,0 LSB first -> 8'h03.
        send_bits(8'h03, 0, 8, 1'b1);
        check_byte("lsb data", data_o, 8'h03);
        check_bit("lsb valid", valid_o, 1'b1);
        end_frame();
        drain();
    endtask

    task automatic test_back_to_back();
        ready_i = 1'b1;
        start_frame(1'b0);
        send_bits(8'h3C, 0, 8, 1'b0);
        check_byte("b2b first data", data_o, 8'h3C);
        check_bit("b2b first valid", valid_o, 1'b1);
        send_bits(8'hC3, 0, 1, 1'b0);
        check_bit("b2b valid drops after accept", valid_o, 1'b0);
        send_bits(8'hC3, 1, 8, 1'b0);
        check_byte("b2b second data", data_o, 8'hC3);
        check_bit("b2b second valid", valid_o, 1'b1);
        check_bit("b2b no overrun", overrun_o, 1'b0);
        end_frame();
        ready_i = 1'b0;
        drain();
    endtask

    task automatic test_overrun();
        start_frame(1'b0);
        send_bits(8'h11, 0, 8, 1'b0);
        check_byte("ovr first data", data_o, 8'h11);
        check_bit("ovr first no overrun", overrun_o, 1'b0);
        send_bits(8'h22, 0, 8, 1'b0);
        check_byte("ovr data kept", data_o, 8'h11);
        check_bit("ovr flag set", overrun_o, 1'b1);
        check_bit("ovr valid held", valid_o, 1'b1);
        // Drop coinciding with a clear: set wins.
        send_bits(8'h33, 0, 7, 1'b0);
        clr_ovr_i = 1'b1;
        send_bits(8'h33, 7, 8, 1'b0);
        clr_ovr_i = 1'b0;
        check_bit("ovr set beats clear", overrun_o, 1'b1);
        check_byte("ovr data still first", data_o, 8'h11);
        clr_ovr_i = 1'b1;
        tick();
        clr_ovr_i = 1'b0;
        check_bit("ovr cleared", overrun_o, 1'b0);
        end_frame();
    endtask

    task automatic test_accept_on_complete();
        // Holding register still has 8'h11 pending.
        start_frame(1'b0);
        send_bits(8'h22, 0, 7, 1'b0);
        ready_i = 1'b1;
        send_bits(8'h22, 7, 8, 1'b0);
        ready_i = 1'b0;
        check_byte("accept+complete data", data_o, 8'h22);
        check_bit("accept+complete valid", valid_o, 1'b1);
        check_bit("accept+complete no overrun", overrun_o, 1'b0);
        end_frame();
        drain();
    endtask

    task automatic test_abort_and_reset();
        start_frame(1'b0);
        send_bits(8'hFF, 0, 5, 1'b0);
        check_bit("abort busy mid word", busy_o, 1'b1);
        end_frame();
        check_bit("abort busy cleared", busy_o, 1'b0);
        check_bit("abort no valid", valid_o, 1'b0);
        check_bit("abort no overrun", overrun_o, 1'b0);
        start_frame(1'b0);
        send_bits(8'hFF, 0, 7, 1'b0);
        check_bit("abort no early completion", valid_o, 1'b0);
        send_bits(8'hFF, 7, 8, 1'b0);
        check_byte("abort new word", data_o, 8'hFF);
        check_bit("abort new word valid", valid_o, 1'b1);

        // Reset mid-word with a word pending and frame held high.
        send_bits(8'hFF, 0, 4, 1'b0);
        #2 rst_i = 1'b1;
        #1;
        check_byte("midreset data_o", data_o, 8'h00);
        check_bit("midreset valid_o", valid_o, 1'b0);
        check_bit("midreset busy_o", busy_o, 1'b0);
        check_bit("midreset overrun_o", overrun_o, 1'b0);
        tick();
        rst_i = 1'b0;
        tick();
        // frame_i stayed high: no fresh rise, strobes must be ignored.
        send_bits(8'h5A, 0, 8, 1'b0);
        check_bit("post-reset strobes ignored valid", valid_o, 1'b0);
        check_bit("post-reset strobes ignored busy", busy_o, 1'b0);
        end_frame();
        start_frame(1'b0);
        send_bits(8'h96, 0, 8, 1'b0);
        check_byte("post-reset fresh frame data", data_o, 8'h96);
        check_bit("post-reset fresh frame valid", valid_o, 1'b1);
        end_frame();
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_overrun();
        test_accept_on_complete();
        test_abort_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
